// File: rtl/tile_rect_drawer.sv
// tile_rect_drawer: streams one framebuffer write per pixel of a
// TILE_W x TILE_H rectangle placed at a tile of a COLS x ROWS grid.
// Handshake: start (sampled in IDLE) / busy / done, with err flagging an
// out-of-range tile index and hold pausing the pixel stream.
// Optional build macro TILE_BORDER_EN adds border_colour: the outermost
// ring of each tile is painted with it, the interior with colour_in.
module tile_rect_drawer #(
    parameter int TILE_W = 36,
    parameter int TILE_H = 36,
    parameter int GAP    = 2,
    parameter int COLS   = 3,
    parameter int ROWS   = 3,
    parameter int X0     = 24,
    parameter int Y0     = 4,
    parameter int LOC_W  = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [LOC_W-1:0] location,
    input  logic [2:0]       colour_in,
`ifdef TILE_BORDER_EN
    input  logic [2:0]       border_colour,
`endif
    input  logic             hold,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       x_out,
    output logic [6:0]       y_out,
    output logic [2:0]       colour_out,
    output logic             write_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Reject parameter sets that would place pixels off the 160x120 screen
    if (TILE_W < 1 || TILE_W > 160) begin : gBadTileW
        $error("tile_rect_drawer: TILE_W must be in 1..160");
    end
    if (TILE_H < 1 || TILE_H > 120) begin : gBadTileH
        $error("tile_rect_drawer: TILE_H must be in 1..120");
    end
    if (X0 + (COLS - 1) * (TILE_W + GAP) + TILE_W > 160) begin : gBadX
        $error("tile_rect_drawer: tile grid exceeds screen width");
    end
    if (Y0 + (ROWS - 1) * (TILE_H + GAP) + TILE_H > 120) begin : gBadY
        $error("tile_rect_drawer: tile grid exceeds screen height");
    end

    localparam logic [7:0] LAST_CX = 8'(TILE_W - 1);
    localparam logic [6:0] LAST_CY = 7'(TILE_H - 1);

    state_t      state_q;
    logic [7:0]  baseX_q;
    logic [6:0]  baseY_q;
    logic [7:0]  cx_q;
    logic [6:0]  cy_q;
    logic [2:0]  fill_q;
    logic [2:0]  border_q;
    logic        invalid_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [7:0]  x_q;
    logic [6:0]  y_q;
    logic [2:0]  colourOut_q;
    logic        write_q;

    logic [31:0] locWide_d;
    logic        locValid_d;
    logic [7:0]  baseX_d;
    logic [6:0]  baseY_d;
    logic [7:0]  cx_d;
    logic [6:0]  cy_d;
    logic        lastCx_d;
    logic        lastPixel_d;
    logic        onBorder_d;
    logic [7:0]  x_d;
    logic [6:0]  y_d;
    logic [2:0]  colour_d;

    // Tile origin from the requested index; div/mod by COLS are constant
    always_comb begin
        locWide_d  = 32'(location);
        locValid_d = (locWide_d < 32'(COLS * ROWS));
        baseX_d    = 8'(X0 + (locWide_d % COLS) * (TILE_W + GAP));
        baseY_d    = 7'(Y0 + (locWide_d / COLS) * (TILE_H + GAP));
    end

    // Raster walk: next counter values and the pixel the current count names
    always_comb begin
        lastCx_d    = (cx_q == LAST_CX);
        lastPixel_d = lastCx_d && (cy_q == LAST_CY);
        cx_d        = cx_q + 8'd1;
        cy_d        = cy_q;
        if (lastCx_d) begin
            cx_d = 8'd0;
            cy_d = cy_q + 7'd1;
        end
        x_d        = baseX_q + cx_q;
        y_d        = baseY_q + cy_q;
        onBorder_d = (cx_q == 8'd0) || lastCx_d || (cy_q == 7'd0) || (cy_q == LAST_CY);
        colour_d   = fill_q;
`ifdef TILE_BORDER_EN
        if (onBorder_d) begin
            colour_d = border_q;
        end
`endif
    end

    // Control FSM with registered handshake and pixel outputs; the tile
    // origin is latched instead of the raw index since that is all DRAW needs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            baseX_q     <= 8'd0;
            baseY_q     <= 7'd0;
            cx_q        <= 8'd0;
            cy_q        <= 7'd0;
            fill_q      <= 3'd0;
            border_q    <= 3'd0;
            invalid_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            x_q         <= 8'd0;
            y_q         <= 7'd0;
            colourOut_q <= 3'd0;
            write_q     <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            write_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !done_q) begin
                        baseX_q   <= baseX_d;
                        baseY_q   <= baseY_d;
                        cx_q      <= 8'd0;
                        cy_q      <= 7'd0;
                        fill_q    <= colour_in;
`ifdef TILE_BORDER_EN
                        border_q  <= border_colour;
`else
                        border_q  <= colour_in;
`endif
                        invalid_q <= !locValid_d;
                        busy_q    <= 1'b1;
                        err_q     <= 1'b0;
                        state_q   <= locValid_d ? DRAW : FIN;
                    end
                end
                DRAW: begin
                    if (!hold) begin
                        x_q         <= x_d;
                        y_q         <= y_d;
                        colourOut_q <= colour_d;
                        write_q     <= 1'b1;
                        cx_q        <= cx_d;
                        cy_q        <= cy_d;
                        if (lastPixel_d) begin
                            state_q <= FIN;
                        end
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    err_q   <= invalid_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign x_out      = x_q;
    assign y_out      = y_q;
    assign colour_out = colourOut_q;
    assign write_out  = write_q;

endmodule

// File: tb/tb_tile_rect_drawer.sv
// tb_tile_rect_drawer: table-driven and randomized checks of tile_rect_drawer
// against a pixel-arithmetic reference model, plus hand sequences for
// reset abort and start handling on a small-tile instance.
module tb_tile_rect_drawer;

    localparam int TW = 36;
    localparam int TH = 36;
    localparam int GP = 2;
    localparam int NC = 3;
    localparam int NR = 3;
    localparam int BX = 24;
    localparam int BY = 4;
`ifdef TILE_BORDER_EN
    localparam bit BORDER_ON = 1'b1;
`else
    localparam bit BORDER_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;

    logic       start = 1'b0;
    logic [3:0] location = 4'd0;
    logic [2:0] colourIn = 3'd0;
    logic [2:0] borderColour = 3'b101;
    logic       hold = 1'b0;
    logic       busy, done, err, writeOut;
    logic [7:0] xOut;
    logic [6:0] yOut;
    logic [2:0] colourOut;

    logic       sStart = 1'b0;
    logic [3:0] sLocation = 4'd1;
    logic [2:0] sColour = 3'b001;
    logic [2:0] sBorder = 3'b111;
    logic       sHold = 1'b0;
    logic       sBusy, sDone, sErr, sWrite;
    logic [7:0] sX;
    logic [6:0] sY;
    logic [2:0] sColourOut;

    int nVec = 0;
    int nMis = 0;

    always #5 clk = ~clk;

    tile_rect_drawer uDut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .location   (location),
        .colour_in  (colourIn),
`ifdef TILE_BORDER_EN
        .border_colour (borderColour),
`endif
        .hold       (hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .x_out      (xOut),
        .y_out      (yOut),
        .colour_out (colourOut),
        .write_out  (writeOut)
    );

    tile_rect_drawer #(.TILE_W(4), .TILE_H(2), .GAP(1), .COLS(2)) uSmall (
        .clk        (clk),
        .resetn     (resetn),
        .start      (sStart),
        .location   (sLocation),
        .colour_in  (sColour),
`ifdef TILE_BORDER_EN
        .border_colour (sBorder),
`endif
        .hold       (sHold),
        .busy       (sBusy),
        .done       (sDone),
        .err        (sErr),
        .x_out      (sX),
        .y_out      (sY),
        .colour_out (sColourOut),
        .write_out  (sWrite)
    );

    typedef struct {
        int         loc;
        logic [2:0] col;
        int         holdMode;
        int         holdAt;
        int         holdX;
        int         holdY;
        int         fx;
        int         fy;
        int         lx;
        int         ly;
        int         writes;
        int         errExp;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        nVec++;
        if (actual !== expected) begin
            nMis++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference colour of pixel p (raster index) in a w x h tile
    function automatic logic [2:0] expColour(input int p, input int w, input int h,
                                             input logic [2:0] fill, input logic [2:0] border);
        bit on;
        on = (p % w == 0) || (p % w == w - 1) || (p / w == 0) || (p / w == h - 1);
        return (on && BORDER_ON) ? border : fill;
    endfunction

    // One full operation on the default-size DUT, checked pixel by pixel.
    // holdMode 0: no hold; 1: random hold plus noise on start/location/colour;
    // 2: hold for 5 cycles right after pixel holdAt has been written.
    task automatic applyStimulus(input int loc, input logic [2:0] col, input int holdMode,
                                 input int holdAt, input int holdX, input int holdY,
                                 output int firstX, output int firstY, output int lastX,
                                 output int lastY, output int nWrites, output logic errSeen);
        int  pix, bx, by, idx, cyc, heldDraw, doneCyc, busyCnt, holdLeft;
        bit  valid, holdUsed, heldNow;
        pix = TW * TH;
        valid = (loc < NC * NR);
        bx = BX + (loc % NC) * (TW + GP);
        by = BY + (loc / NC) * (TH + GP);
        firstX = -1; firstY = -1; lastX = -1; lastY = -1;
        idx = 0; cyc = 0; heldDraw = 0; doneCyc = -1; busyCnt = 1; holdLeft = 0; holdUsed = 0;

        location = 4'(loc);
        colourIn = col;
        hold = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy_after_accept", 32'(busy), 1);

        while (cyc < 6000 && doneCyc < 0) begin
            hold = 1'b0;
            if (holdMode == 1) begin
                hold = ($urandom_range(0, 3) == 0);
                start = ($urandom_range(0, 7) == 0);
                location = 4'($urandom);
                colourIn = 3'($urandom);
            end else if (holdMode == 2) begin
                if (idx == holdAt + 1 && !holdUsed) begin
                    holdLeft = 5;
                    holdUsed = 1;
                end
                if (holdLeft > 0) begin
                    hold = 1'b1;
                    holdLeft--;
                end
            end
            heldNow = hold;
            if (hold && valid && idx < pix) heldDraw++;
            @(posedge clk); #1;
            cyc++;
            if (writeOut === 1'b1) begin
                if (idx < pix) begin
                    checkOutput("pixel_x", 32'(xOut), bx + idx % TW);
                    checkOutput("pixel_y", 32'(yOut), by + idx / TW);
                    checkOutput("pixel_colour", 32'(colourOut),
                                32'(expColour(idx, TW, TH, col, borderColour)));
                end
                if (idx == 0) begin
                    firstX = int'(xOut);
                    firstY = int'(yOut);
                end
                lastX = int'(xOut);
                lastY = int'(yOut);
                idx++;
            end
            if (heldNow) begin
                checkOutput("hold_write_low", 32'(writeOut), 0);
                if (valid && idx > 0) begin
                    checkOutput("hold_x_frozen", 32'(xOut), bx + (idx - 1) % TW);
                    checkOutput("hold_y_frozen", 32'(yOut), by + (idx - 1) / TW);
                end
                if (holdX >= 0) begin
                    checkOutput("hold_x_table", 32'(xOut), holdX);
                    checkOutput("hold_y_table", 32'(yOut), holdY);
                end
            end
            if (done === 1'b1) doneCyc = cyc;
            else if (busy === 1'b1) busyCnt++;
        end
        start = 1'b0;
        hold = 1'b0;

        if (doneCyc < 0) checkOutput("done_timeout", 0, 1);
        checkOutput("write_count", idx, valid ? pix : 0);
        checkOutput("done_cycle", doneCyc, valid ? pix + heldDraw + 1 : 1);
        checkOutput("busy_cycles", busyCnt, valid ? pix + heldDraw + 1 : 1);
        checkOutput("busy_low_at_done", 32'(busy), 0);
        checkOutput("err_with_done", 32'(err), valid ? 0 : 1);
        errSeen = err;
        nWrites = idx;
        @(posedge clk); #1;
        checkOutput("done_one_cycle", 32'(done), 0);
        checkOutput("err_sticky", 32'(err), valid ? 0 : 1);
    endtask

    // Waits for one small-tile draw to finish, checking every write
    task automatic smallDraw(input int bx, input int changeLocTo, output int nWrites,
                             output int firstX, output int firstY);
        int  cyc;
        bit  seen;
        cyc = 0; seen = 0; nWrites = 0; firstX = -1; firstY = -1;
        while (cyc < 100 && !seen) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 3) sLocation = 4'(changeLocTo);
            if (sWrite === 1'b1) begin
                if (nWrites == 0) begin
                    firstX = int'(sX);
                    firstY = int'(sY);
                end
                if (nWrites < 8) begin
                    checkOutput("small_x", 32'(sX), bx + nWrites % 4);
                    checkOutput("small_y", 32'(sY), 4 + nWrites / 4);
                    checkOutput("small_colour", 32'(sColourOut), BORDER_ON ? 7 : 1);
                end
                nWrites++;
            end
            if (sDone === 1'b1) seen = 1;
        end
        if (!seen) checkOutput("small_done_timeout", 0, 1);
    endtask

    initial begin
        int fx, fy, lx, ly, nw, idx, cyc;
        logic es;

        #100_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, limit %0d", 100_000_000);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int fx, fy, lx, ly, nw, idx, cyc;
        logic es;

        vecs[0] = '{0, 3'b100, 0, 0, -1, -1, 24, 4, 59, 39, 1296, 0};
        vecs[1] = '{8, 3'b010, 0, 0, -1, -1, 100, 80, 135, 115, 1296, 0};
        vecs[2] = '{9, 3'b001, 0, 0, -1, -1, -1, -1, -1, -1, 0, 1};
        vecs[3] = '{4, 3'b011, 2, 100, 90, 44, 62, 42, 97, 77, 1296, 0};
        vecs[4] = '{15, 3'b110, 0, 0, -1, -1, -1, -1, -1, -1, 0, 1};
        vecs[5] = '{5, 3'b111, 1, 0, -1, -1, 100, 42, 135, 77, 1296, 0};

        #12;
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_err", 32'(err), 0);
        checkOutput("reset_write", 32'(writeOut), 0);
        checkOutput("reset_x", 32'(xOut), 0);
        checkOutput("reset_y", 32'(yOut), 0);
        checkOutput("reset_colour", 32'(colourOut), 0);
        #10;
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].loc, vecs[i].col, vecs[i].holdMode, vecs[i].holdAt,
                          vecs[i].holdX, vecs[i].holdY, fx, fy, lx, ly, nw, es);
            checkOutput("table_first_x", fx, vecs[i].fx);
            checkOutput("table_first_y", fy, vecs[i].fy);
            checkOutput("table_last_x", lx, vecs[i].lx);
            checkOutput("table_last_y", ly, vecs[i].ly);
            checkOutput("table_writes", nw, vecs[i].writes);
            checkOutput("table_err", 32'(es), vecs[i].errExp);
        end

        for (int r = 0; r < 6; r++) begin
            applyStimulus(int'($urandom_range(0, 15)), 3'($urandom), 1, 0, -1, -1,
                          fx, fy, lx, ly, nw, es);
        end

        // Abort a draw with reset at pixel 500, then draw tile 1
        location = 4'd0;
        colourIn = 3'b100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 500 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (writeOut === 1'b1) idx++;
        end
        checkOutput("abort_reached_500", idx, 500);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("abort_write_async", 32'(writeOut), 0);
        checkOutput("abort_busy_async", 32'(busy), 0);
        checkOutput("abort_x_async", 32'(xOut), 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checkOutput("abort_no_done", 32'(done), 0);
            checkOutput("abort_no_write", 32'(writeOut), 0);
        end
        applyStimulus(1, 3'b110, 0, 0, -1, -1, fx, fy, lx, ly, nw, es);
        checkOutput("after_abort_first_x", fx, 62);
        checkOutput("after_abort_first_y", fy, 4);
        checkOutput("after_abort_last_x", lx, 97);
        checkOutput("after_abort_last_y", ly, 39);
        checkOutput("after_abort_writes", nw, 1296);

        // Small tiles: start held high through the draw and past done
        sLocation = 4'd1;
        sColour = 3'b001;
        sBorder = 3'b111;
        sStart = 1'b1;
        smallDraw(29, 0, nw, fx, fy);
        checkOutput("small_writes", nw, 8);
        checkOutput("small_first_x", fx, 29);
        checkOutput("small_first_y", fy, 4);
        checkOutput("small_err", 32'(sErr), 0);
        checkOutput("small_busy_at_done", 32'(sBusy), 0);
        @(posedge clk); #1;
        checkOutput("small_start_ignored_on_done", 32'(sBusy), 0);
        @(posedge clk); #1;
        checkOutput("small_start_accepted_next", 32'(sBusy), 1);
        sStart = 1'b0;
        smallDraw(24, 0, nw, fx, fy);
        checkOutput("small2_writes", nw, 8);
        checkOutput("small2_first_x", fx, 24);
        checkOutput("small2_first_y", fy, 4);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
